// File: rtl/two_bit_serial_comparator.sv
// Serial magnitude comparator: compares two WIDTH-bit operands CHUNK bits per cycle, MSB slice first.
// Latency: start captured at edge 0; done pulses in cycle j+2 (j = first differing slice) or N+1 if equal.
// Backpressure: none; start is only sampled in IDLE, so a request while busy/done is dropped.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset_n      synchronous active-low reset
//   start        compare request, sampled only in IDLE
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   a, b         operands (captured on the accepting edge)
//   busy         high while slices are being compared (RUN)
//   done         one-cycle pulse, result valid
//   gt, eq, lt   result flags, held until the next completed compare
module two_bit_serial_comparator #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // WIDTH must be a non-zero multiple of CHUNK; N is the slice count.
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sgn_q, sgn_d;
  logic              gt_q, gt_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;

  // Operands as seen by the unsigned slice compare.
  logic [WIDTH-1:0]  a_op, b_op;
  logic [CHUNK-1:0]  a_sl, b_sl;
  logic              last_slice;

  // Flipping both sign bits maps two's-complement order onto unsigned
  // order, so a single unsigned slice comparator serves both modes.
  always_comb begin
    a_op = a_q;
    b_op = b_q;
    a_op[WIDTH-1] = a_q[WIDTH-1] ^ sgn_q;
    b_op[WIDTH-1] = b_q[WIDTH-1] ^ sgn_q;
  end

  // Slice select as a constant-indexed mux: slice s sits at the top of
  // the word minus s*CHUNK bits.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int s = 0; s < N; s++) begin
      if (idx_q == IDXW'(s)) begin
        a_sl = a_op[WIDTH-1-s*CHUNK -: CHUNK];
        b_sl = b_op[WIDTH-1-s*CHUNK -: CHUNK];
      end
    end
  end

  assign last_slice = (idx_q == IDXW'(N - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // The first differing slice decides; lower slices cannot change it.
        if (a_sl > b_sl) begin
          gt_d    = 1'b1;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else if (a_sl < b_sl) begin
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (last_slice) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_two_bit_serial_comparator.sv
// Directed bench for two_bit_serial_comparator: an 8-bit/2-bit-slice instance and a 16-bit single-slice instance.
// Cycle k is the interval after rising edge k-1, with the start captured at edge 0; outputs sampled on the falling edge.
// Inputs are driven on the falling edge; each step lists hand-computed busy/done timing and result flags.
module tb_two_bit_serial_comparator;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, gt8, eq8, lt8;

  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16, gt16, eq16, lt16;

  int          vec = 0;
  int          miscmp = 0;

  logic        sel_v = 1'b0;
  logic        busy_s, done_s;
  logic [2:0]  res_s;

  always #5 clk = ~clk;

  two_bit_serial_comparator #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  two_bit_serial_comparator #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .gt(gt16), .eq(eq16), .lt(lt16)
  );

  always_comb begin
    busy_s = sel_v ? busy16 : busy8;
    done_s = sel_v ? done16 : done8;
    res_s  = sel_v ? {gt16, eq16, lt16} : {gt8, eq8, lt8};
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One compare on the selected instance; res is {gt,eq,lt}.
  task automatic run_cmp(input string tag, input logic sel, input logic [15:0] av,
                         input logic [15:0] bv, input logic sm, input int dcyc,
                         input logic [2:0] res);
    @(negedge clk);
    sel_v = sel;
    if (sel) begin
      a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; start8 = 1'b1;
    end
    @(posedge clk);
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      start8  = 1'b0;
      start16 = 1'b0;
      chk({tag, "_busy"}, 3'(busy_s), 3'(c < dcyc));
      chk({tag, "_done"}, 3'(done_s), 3'(c == dcyc));
    end
    chk({tag, "_res"}, res_s, res);
    @(negedge clk);
    chk({tag, "_idle_done"}, 3'(done_s), 3'b000);
    chk({tag, "_idle_busy"}, 3'(busy_s), 3'b000);
    chk({tag, "_hold"}, res_s, res);
  endtask

  initial begin
    reset_n = 1'b0;
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;

    // Reset with start held high: start must be ignored.
    repeat (3) @(negedge clk);
    chk("rst_busy8", 3'(busy8), 3'b000);
    chk("rst_done8", 3'(done8), 3'b000);
    chk("rst_res8", {gt8, eq8, lt8}, 3'b000);
    chk("rst_busy16", 3'(busy16), 3'b000);
    chk("rst_res16", {gt16, eq16, lt16}, 3'b000);
    start8 = 1'b0; start16 = 1'b0;
    reset_n = 1'b1;

    // Unsigned: top slice 10 vs 01.
    run_cmp("a5_5a_u", 1'b0, 16'h00A5, 16'h005A, 1'b0, 2, 3'b100);
    // Signed: -91 < 90, decided in the top slice.
    run_cmp("a5_5a_s", 1'b0, 16'h00A5, 16'h005A, 1'b1, 2, 3'b001);
    // Differ only in the last slice (00 vs 11).
    run_cmp("34_37_u", 1'b0, 16'h0034, 16'h0037, 1'b0, 5, 3'b001);
    // Equal operands walk all four slices.
    run_cmp("3c_3c_u", 1'b0, 16'h003C, 16'h003C, 1'b0, 5, 3'b010);
    // Third slice differs (11 vs 10).
    run_cmp("4c_48_u", 1'b0, 16'h004C, 16'h0048, 1'b0, 4, 3'b100);
    // Signed extremes: -128 < 127 and -1 > -128.
    run_cmp("80_7f_s", 1'b0, 16'h0080, 16'h007F, 1'b1, 2, 3'b001);
    run_cmp("ff_80_s", 1'b0, 16'h00FF, 16'h0080, 1'b1, 2, 3'b100);
    // Equal in signed mode.
    run_cmp("c3_c3_s", 1'b0, 16'h00C3, 16'h00C3, 1'b1, 5, 3'b010);

    // Operand/mode changes and a second start during RUN must be ignored.
    @(negedge clk);
    sel_v = 1'b0;
    a8 = 8'h00; b8 = 8'h01; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      chk("chg_busy", 3'(busy8), 3'(c < 5));
      chk("chg_done", 3'(done8), 3'(c == 5));
    end
    chk("chg_res", {gt8, eq8, lt8}, 3'b001);
    @(negedge clk);
    chk("chg_no_restart", 3'(busy8), 3'b000);
    chk("chg_no_done", 3'(done8), 3'b000);

    // Reset mid-RUN aborts with no done pulse and clears the flags.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h3C; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    chk("abort_busy_c1", 3'(busy8), 3'b001);
    @(negedge clk);
    chk("abort_busy_c2", 3'(busy8), 3'b001);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_c3", 3'(busy8), 3'b000);
    chk("abort_done_c3", 3'(done8), 3'b000);
    chk("abort_res", {gt8, eq8, lt8}, 3'b000);
    start8 = 1'b1;
    @(negedge clk);
    chk("abort_start_in_rst", 3'(busy8), 3'b000);
    start8 = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_done", 3'(done8), 3'b000);
    end
    chk("abort_res_held", {gt8, eq8, lt8}, 3'b000);

    // Accepts a fresh compare after the abort.
    run_cmp("12_11_u", 1'b0, 16'h0012, 16'h0011, 1'b0, 5, 3'b100);

    // Single-slice instance: done always in cycle 2.
    run_cmp("w16_s", 1'b1, 16'h8000, 16'h7FFF, 1'b1, 2, 3'b001);
    run_cmp("w16_u", 1'b1, 16'h8000, 16'h7FFF, 1'b0, 2, 3'b100);
    run_cmp("w16_eq", 1'b1, 16'h1234, 16'h1234, 1'b0, 2, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/two_bit_serial_comparator.md
TWO_BIT_SERIAL_COMPARATOR -- requirements
Module: two_bit_serial_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be a multiple of CHUNK and >= CHUNK.
REQ-002 Parameter CHUNK, default 2, bits compared per clock cycle; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request a compare; sampled only in IDLE.
REQ-006 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 busy  output  1  high while a compare is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 gt  output  1  A > B.
REQ-012 eq  output  1  A == B.
REQ-013 lt  output  1  A < B.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE. busy = (state == RUN). done = (state == DONE).
REQ-015 IDLE with start=1 at a rising edge: the block SHALL latch a, b and signed_mode, clear the slice index to 0, and enter RUN.
REQ-016 start SHALL be ignored in RUN and DONE; operand and mode changes after capture SHALL NOT affect the result.
REQ-017 In signed mode the latched MSB of both operands SHALL be inverted before comparison; unsigned mode uses the operands unchanged.
REQ-018 Slices SHALL be compared MSB first. Slice i is bits [WIDTH-1-i*CHUNK -: CHUNK]. There are N = WIDTH/CHUNK slices.
REQ-019 Each RUN cycle SHALL compare one slice as unsigned CHUNK-bit values.
REQ-020 If the current slice of A is greater than that of B: set gt=1, eq=0, lt=0 and go to DONE (early exit).
REQ-021 If the current slice of A is less than that of B: set lt=1, gt=0, eq=0 and go to DONE (early exit).
REQ-022 If the slices are equal and i = N-1: set eq=1, gt=0, lt=0 and go to DONE.
REQ-023 If the slices are equal and i < N-1: increment i and remain in RUN.
REQ-024 Latency, with start captured at edge 0 and j = index of the first differing slice: busy is high in cycles 1..j+1 and done is high in cycle j+2.
REQ-025 Latency when the operands are equal: busy is high in cycles 1..N and done is high in cycle N+1.
REQ-026 DONE SHALL last exactly one cycle and then return to IDLE. A new start is accepted no earlier than the cycle after done.
REQ-027 gt, eq and lt SHALL update only on the edge entering DONE, and SHALL hold their values until the next DONE entry.
REQ-028 Exactly one of gt, eq, lt SHALL be high after the first completed compare.
REQ-029 When CHUNK = WIDTH, every compare SHALL complete with done in cycle 2.

Reset
REQ-030 reset_n=0 at a rising edge SHALL force state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, and the slice index and latched operands to 0, regardless of the current state.
REQ-031 Reset asserted mid-RUN SHALL abort the compare with no done pulse. Outputs SHALL remain at reset values until a new compare completes.
REQ-032 While reset_n=0, start SHALL be ignored.

Verification (WIDTH=8, CHUNK=2 unless noted)
REQ-033 a=0xA5, b=0x5A, signed_mode=0, start pulse -> busy cycle 1, done cycle 2, gt=1 eq=0 lt=0.
REQ-034 a=0xA5, b=0x5A, signed_mode=1 -> done cycle 2, lt=1 gt=0 eq=0.
REQ-035 a=0x34, b=0x37, signed_mode=0 -> busy cycles 1-4, done cycle 5, lt=1. Also a=b=0x3C -> done cycle 5, eq=1.
REQ-036 Start a=0x00, b=0x01; change a/b and pulse start during cycles 1-3 -> changes ignored; done cycle 5 with lt=1; the second start has no effect.
REQ-037 Start a=0x3C, b=0x3C; drive reset_n=0 at cycle 2 -> busy=0 next cycle, no done pulse, gt=eq=lt=0.
REQ-038 WIDTH=16, CHUNK=16, a=0x8000, b=0x7FFF: signed_mode=1 -> done cycle 2, lt=1; signed_mode=0 -> gt=1.
